// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants, types and helpers for the writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned SEL_W  = $clog2(N_REQ);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(31);

  // Requester indices double as writeback mux select codes.
  typedef enum logic [SEL_W-1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_MUL  = 2'd2,
    WB_LINK = 2'd3
  } wb_src_e;

  // Registered writeback payload toward the register file.
  typedef struct packed {
    logic                en;
    wb_src_e             sel;
    logic [REG_W-1:0]    rd;
    logic [DATA_W-1:0]   data;
  } wb_out_t;

  // Writes to the hard-wired zero register never reach the register file.
  function automatic logic is_zero_reg(input logic [REG_W-1:0] rd);
    return rd == ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester handshake and register-file writeback bus.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][DATA_W-1:0] req_data;
  logic [N_REQ-1:0][REG_W-1:0]  req_rd;
  logic [N_REQ-1:0]             req_ready;
  wb_src_e                      wb_sel;
  logic                         wb_en;
  logic [REG_W-1:0]             wb_rd;
  logic [DATA_W-1:0]            wb_data;
  logic                         busy;

  // Producer side: presents results, observes accept and writeback.
  modport master (
    output req_valid, req_data, req_rd,
    input  req_ready, wb_sel, wb_en, wb_rd, wb_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_rd,
    output req_ready, wb_sel, wb_en, wb_rd, wb_data, busy
  );

endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// N-way round-robin arbiter; search starts at the pointer and wraps.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_vld_c
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // First valid requester at or after the pointer wins; pointer moves past it.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    ptr_d       = ptr_q;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!grant_vld_c && req[IDX_W'((32'(ptr_q) + i) % N)]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = IDX_W'((32'(ptr_q) + i) % N);
        end
      end
    end
    if (grant_vld_c) begin
      grant_c[grant_idx_c] = 1'b1;
      ptr_d                = IDX_W'((32'(grant_idx_c) + 32'd1) % N);
    end
  end

  // Priority pointer; resets to index 0 (highest priority first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between ALU, load, mul and link results.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  wb_port_arbiter_if.slave  bus
);

  logic                 arb_en_c;
  logic [N_REQ-1:0]     grant_c;
  logic [SEL_W-1:0]     grant_idx_c;
  logic                 grant_vld_c;
  logic [DATA_W-1:0]    data_mux_c;
  logic [REG_W-1:0]     rd_mux_c;
  wb_out_t              wb_q;
  wb_out_t              wb_d;

  // Flush blocks all grants; no grant while reset is held.
  assign arb_en_c = ~flush & rst_n;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (arb_en_c),
    .req         (bus.req_valid),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_vld_c (grant_vld_c)
  );

  // Winner payload selection.
  always_comb begin
    data_mux_c = bus.req_data[grant_idx_c];
    rd_mux_c   = bus.req_rd[grant_idx_c];
  end

  // Next writeback: capture on accept, hold payload when idle, pulse enable once.
  always_comb begin
    wb_d    = wb_q;
    wb_d.en = 1'b0;
    if (grant_vld_c) begin
      wb_d.en   = ~is_zero_reg(rd_mux_c);
      wb_d.sel  = wb_src_e'(grant_idx_c);
      wb_d.rd   = rd_mux_c;
      wb_d.data = data_mux_c;
    end
  end

  // Writeback output register; clears immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign bus.req_ready = grant_c;
  assign bus.busy      = |(bus.req_valid & ~grant_c);
  assign bus.wb_en     = wb_q.en;
  assign bus.wb_sel    = wb_q.sel;
  assign bus.wb_rd     = wb_q.rd;
  assign bus.wb_data   = wb_q.data;

endmodule
